// File: rtl/pipeline_defs.sv
// Shared definitions for the ARM pipeline front end: word width, fetch FSM
// encoding and the default fetch constants.
package pipeline_defs;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_START   = 2'd0,
        ST_FETCH   = 2'd1,
        ST_READY   = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

    localparam word_t DEF_PC_INC    = 32'd4;
    localparam word_t DEF_NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Request/acknowledge read channel between the fetch unit and instruction memory.
interface if_fetch_unit_if;
    import pipeline_defs::*;

    logic  mem_req;
    word_t mem_addr;
    logic  mem_ack;
    word_t mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/pc_reg.sv
// Program counter: async reset to RESET_PC, load enable, sequential/branch select.
module pc_reg
    import pipeline_defs::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000,
    parameter word_t PC_INC   = DEF_PC_INC
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  sel_branch,
    input  word_t branch_addr,
    output word_t pc,
    output word_t pc_next_c
);

    // Next value is exposed so the fetch address register can track it.
    always_comb begin
        pc_next_c = pc;
        if (load) begin
            pc_next_c = sel_branch ? branch_addr : pc + PC_INC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next_c;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the req/ack fetch to memory and
// presents {PC+4, instruction, valid} to the IF/ID register.
module if_fetch_unit
    import pipeline_defs::*;
#(
    parameter word_t RESET_PC  = 32'h0000_0000,
    parameter word_t PC_INC    = DEF_PC_INC,
    parameter word_t NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  word_t                  branch_addr,
    if_fetch_unit_if.master        bus,
    output word_t                  PC,
    output word_t                  instruction,
    output logic                   if_valid
);

    fetch_state_t state_q;
    fetch_state_t state_next;
    logic         pc_load;
    logic         pc_sel_branch;
    logic         capture;
    word_t        pc;
    word_t        pc_next_c;

    pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (pc_load),
        .sel_branch  (pc_sel_branch),
        .branch_addr (branch_addr),
        .pc          (pc),
        .pc_next_c   (pc_next_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_START;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state and PC control; a redirect always outranks freeze.
    always_comb begin
        state_next    = state_q;
        pc_load       = 1'b0;
        pc_sel_branch = 1'b0;
        capture       = 1'b0;
        unique case (state_q)
            ST_START: begin
                state_next = ST_FETCH;
                if (branch_taken) begin
                    pc_load       = 1'b1;
                    pc_sel_branch = 1'b1;
                end
            end
            ST_FETCH: begin
                if (branch_taken) begin
                    pc_load       = 1'b1;
                    pc_sel_branch = 1'b1;
                    state_next    = bus.mem_ack ? ST_FETCH : ST_DISCARD;
                end else if (bus.mem_ack) begin
                    capture    = 1'b1;
                    state_next = ST_READY;
                end
            end
            ST_DISCARD: begin
                if (branch_taken) begin
                    pc_load       = 1'b1;
                    pc_sel_branch = 1'b1;
                end
                if (bus.mem_ack) begin
                    state_next = ST_FETCH;
                end
            end
            ST_READY: begin
                if (branch_taken) begin
                    pc_load       = 1'b1;
                    pc_sel_branch = 1'b1;
                    state_next    = ST_FETCH;
                end else if (!freeze) begin
                    pc_load    = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_START;
        endcase
    end

    // Request is a pure state decode so reset drops it asynchronously.
    assign bus.mem_req = (state_q == ST_FETCH) || (state_q == ST_DISCARD);

    // DISCARD keeps the stale address on the bus until its ack retires it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_addr <= RESET_PC;
            PC           <= '0;
            instruction  <= NOP_INSTR;
            if_valid     <= 1'b0;
        end else begin
            if (state_next != ST_DISCARD) begin
                bus.mem_addr <= pc_next_c;
            end
            if_valid <= (state_next == ST_READY);
            if (capture) begin
                PC          <= pc + PC_INC;
                instruction <= bus.mem_rdata;
            end else if (state_next != ST_READY) begin
                instruction <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit against a behavioural memory with
// programmable wait states and address-derived read data.
module tb_if_fetch_unit;
    import pipeline_defs::*;

    logic  clk;
    logic  rst;
    logic  freeze;
    logic  branch_taken;
    word_t branch_addr;
    word_t PC;
    word_t instruction;
    logic  if_valid;

    int checks;
    int failures;
    int wait_cycles;
    int cnt;
    int addr_viol;
    logic  prev_req;
    logic  prev_ack;
    word_t prev_addr;

    if_fetch_unit_if mem_bus ();

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .bus          (mem_bus.master),
        .PC           (PC),
        .instruction  (instruction),
        .if_valid     (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd8) return 32'hE3A0_1005;
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory acks after wait_cycles full cycles of request.
    assign mem_bus.mem_ack   = mem_bus.mem_req && (cnt == wait_cycles);
    assign mem_bus.mem_rdata = mem_word(mem_bus.mem_addr);

    always @(posedge clk or posedge rst) begin
        if (rst) cnt <= 0;
        else if (mem_bus.mem_req && !mem_bus.mem_ack) cnt <= cnt + 1;
        else cnt <= 0;
    end

    // Address must stay put for an unacknowledged request.
    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (prev_req && !prev_ack && mem_bus.mem_req && mem_bus.mem_addr !== prev_addr)
                addr_viol++;
            prev_req  = mem_bus.mem_req;
            prev_ack  = mem_bus.mem_ack;
            prev_addr = mem_bus.mem_addr;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!if_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(if_valid), 32'd1);
    endtask

    initial begin
        checks = 0; failures = 0; addr_viol = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        wait_cycles = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_req", 32'(mem_bus.mem_req), 32'd0);
        check_eq("rst_addr", mem_bus.mem_addr, 32'h0);
        check_eq("rst_pc", PC, 32'h0);
        check_eq("rst_instr", instruction, 32'h0);
        check_eq("rst_valid", 32'(if_valid), 32'd0);
        rst = 1'b0;

        // Zero-wait sequential fetches at 0, 4, 8
        @(negedge clk);
        check_eq("f0_req", 32'(mem_bus.mem_req), 32'd1);
        check_eq("f0_addr", mem_bus.mem_addr, 32'h0);
        check_eq("f0_valid", 32'(if_valid), 32'd0);
        @(negedge clk);
        check_eq("r0_valid", 32'(if_valid), 32'd1);
        check_eq("r0_pc", PC, 32'h4);
        check_eq("r0_instr", instruction, 32'hC0DE_0000);
        @(negedge clk);
        check_eq("f1_addr", mem_bus.mem_addr, 32'h4);
        check_eq("f1_valid", 32'(if_valid), 32'd0);
        check_eq("f1_nop", instruction, 32'h0);
        @(negedge clk);
        check_eq("r1_pc", PC, 32'h8);
        check_eq("r1_instr", instruction, 32'hC0DE_0004);
        @(negedge clk);
        check_eq("f2_addr", mem_bus.mem_addr, 32'h8);
        @(negedge clk);
        check_eq("r2_valid", 32'(if_valid), 32'd1);
        check_eq("r2_pc", PC, 32'hC);
        check_eq("r2_instr", instruction, 32'hE3A0_1005);

        // Freeze holds READY for five cycles
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("frz_valid", 32'(if_valid), 32'd1);
            check_eq("frz_pc", PC, 32'hC);
            check_eq("frz_instr", instruction, 32'hE3A0_1005);
            check_eq("frz_req", 32'(mem_bus.mem_req), 32'd0);
        end
        freeze = 1'b0;
        wait_cycles = 3;

        // Three wait states: request held four cycles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("ws_req", 32'(mem_bus.mem_req), 32'd1);
            check_eq("ws_addr", mem_bus.mem_addr, 32'hC);
            check_eq("ws_valid", 32'(if_valid), 32'd0);
        end
        @(negedge clk);
        check_eq("ws_rvalid", 32'(if_valid), 32'd1);
        check_eq("ws_pc", PC, 32'h10);
        check_eq("ws_instr", instruction, 32'hC0DE_000C);

        // Branch during an outstanding fetch: stale word dropped
        wait_cycles = 2;
        @(negedge clk);
        check_eq("br_addr0", mem_bus.mem_addr, 32'h10);
        branch_taken = 1'b1;
        branch_addr  = 32'h40;
        @(negedge clk);
        branch_taken = 1'b0;
        check_eq("dis_req", 32'(mem_bus.mem_req), 32'd1);
        check_eq("dis_addr", mem_bus.mem_addr, 32'h10);
        check_eq("dis_valid", 32'(if_valid), 32'd0);
        @(negedge clk);
        check_eq("dis_addr2", mem_bus.mem_addr, 32'h10);
        check_eq("dis_valid2", 32'(if_valid), 32'd0);
        @(negedge clk);
        check_eq("br_req", 32'(mem_bus.mem_req), 32'd1);
        check_eq("br_addr", mem_bus.mem_addr, 32'h40);
        check_eq("br_valid", 32'(if_valid), 32'd0);
        wait_valid("br_wait");
        check_eq("br_pc", PC, 32'h44);
        check_eq("br_instr", instruction, 32'hC0DE_0040);

        // Branch and freeze together in READY: redirect wins
        wait_cycles  = 0;
        freeze       = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h80;
        @(negedge clk);
        freeze       = 1'b0;
        branch_taken = 1'b0;
        check_eq("bf_req", 32'(mem_bus.mem_req), 32'd1);
        check_eq("bf_addr", mem_bus.mem_addr, 32'h80);
        check_eq("bf_valid", 32'(if_valid), 32'd0);
        @(negedge clk);
        check_eq("bf_pc", PC, 32'h84);
        check_eq("bf_instr", instruction, 32'hC0DE_0080);

        // Reset in the middle of a wait-state fetch
        wait_cycles = 3;
        @(negedge clk);
        check_eq("mr_addr", mem_bus.mem_addr, 32'h84);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mr_req", 32'(mem_bus.mem_req), 32'd0);
        check_eq("mr_valid", 32'(if_valid), 32'd0);
        check_eq("mr_rstaddr", mem_bus.mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_cycles = 0;
        @(negedge clk);
        check_eq("mr_req2", 32'(mem_bus.mem_req), 32'd1);
        check_eq("mr_addr2", mem_bus.mem_addr, 32'h0);
        @(negedge clk);
        check_eq("mr_pc", PC, 32'h4);
        check_eq("mr_rvalid", 32'(if_valid), 32'd1);

        // PC wrap at the top of the address space
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        @(negedge clk);
        branch_taken = 1'b0;
        check_eq("wr_addr", mem_bus.mem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        check_eq("wr_pc", PC, 32'h0);
        check_eq("wr_instr", instruction, 32'hC0DE_FFFC);
        @(negedge clk);
        check_eq("wr_req", 32'(mem_bus.mem_req), 32'd1);
        check_eq("wr_next", mem_bus.mem_addr, 32'h0);

        check_eq("addr_hold", 32'(addr_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end of the ARM pipeline; the producer side of the IF/ID pipeline register.
- Owns the program counter and runs a req/ack read handshake to instruction memory. Presents {PC+4, instruction, valid} to the IF/ID register.
- Honours freeze from the hazard unit and branch redirects from EXE.
- Drops in-flight fetches that a branch makes stale.

Parameters:
RESET_PC, 32'h0000_0000, address of first fetched instruction after reset
PC_INC, 4, byte increment between sequential instructions
NOP_INSTR, 32'h0000_0000, instruction value driven when if_valid=0

Ports:
clk  in  1  pipeline clock, rising-edge
rst  in  1  asynchronous, active-high reset
freeze  in  1  hazard stall; hold current instruction, do not advance PC
branch_taken  in  1  redirect request from EXE (same signal as IF/ID flush)
branch_addr  in  32  redirect target, byte address, word-aligned
mem_req  out  1  fetch request to instruction memory
mem_addr  out  32  fetch address, stable while mem_req=1
mem_ack  in  1  single-cycle; mem_rdata valid this cycle
mem_rdata  in  32  fetched instruction word
PC  out  32  address of presented instruction + PC_INC (to IF/ID PCIn)
instruction  out  32  presented instruction (to IF/ID instructionIn)
if_valid  out  1  PC/instruction valid; top uses !if_valid to flush IF/ID (bubble)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Reset values: state=START, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, PC=0, instruction=NOP_INSTR, if_valid=0.
- States: START, FETCH, READY, DISCARD.
- START: mem_req=0. Go to FETCH next cycle. If branch_taken, first load pc<=branch_addr.
- FETCH: mem_req=1, mem_addr=pc, if_valid=0.
  - On mem_ack && !branch_taken: instr_buf<=mem_rdata, PC<=pc+PC_INC, go READY.
  - On branch_taken with mem_ack: drop data, pc<=branch_addr, stay FETCH. New address appears next cycle.
  - On branch_taken without mem_ack: pc<=branch_addr, go DISCARD.
- DISCARD: mem_req=1 and mem_addr holds the stale address. The handshake may not be abandoned.
  - On mem_ack: drop data, go FETCH.
  - A further branch_taken only updates pc; last branch wins.
- READY: if_valid=1; instruction/PC hold the captured values.
  - branch_taken: go FETCH with pc<=branch_addr; if_valid=0 next cycle. Branch has priority over freeze.
  - Else freeze: hold everything.
  - Else: pc<=pc+PC_INC, go FETCH.
- Handshake rules:
  - mem_req stays 1 until mem_ack. mem_addr must not change while mem_req=1.
  - mem_ack may arrive in the first cycle of mem_req (zero-wait memory).
  - mem_ack outside FETCH/DISCARD is ignored.
- Throughput: 2 cycles/instruction with zero-wait memory (FETCH, READY); READY lasts longer under freeze.
- Width: pc arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0, no flag. The low two bits of branch_addr are passed through unchanged.
- Reset mid-fetch: the outstanding request is abandoned and mem_req falls asynchronously. Memory must tolerate this; it is the only exception to the hold rule.

Decomposition:
- Shared package pipeline_defs holds:
  - fetch state encoding (2-bit: START=0, FETCH=1, READY=2, DISCARD=3)
  - NOP_INSTR constant
  - PC_INC constant
  - the 32-bit word width
- One natural sub-module: pc_reg (32-bit register with async reset to RESET_PC, load-enable, and a next-value mux for sequential vs. branch_addr).
- The FSM and output registers stay in if_fetch_unit.

Test Plan:
- Reset, zero-wait memory returning addr-derived data: first mem_req at addr 0, then 4, 8. PC=4,8,12 with instruction=mem[addr]; if_valid toggles 0/1.
- Memory with 3 wait cycles: mem_req/mem_addr held stable 4 cycles per fetch, if_valid=0 throughout; instruction appears only after ack.
- freeze=1 in READY for 5 cycles, instr 32'hE3A01005 at addr 8: PC=12 and instruction=32'hE3A01005 held, no new mem_req. Release: fetch at 12.
- branch_taken with branch_addr=32'h40 during FETCH, memory 2 wait cycles: old addr held until ack, data dropped, next request at 32'h40, and if_valid never shows the stale word.
- branch_taken and freeze together in READY: redirect wins; next mem_addr=branch_addr, if_valid=0.
- rst asserted mid-wait: mem_req=0, if_valid=0 immediately (async). After release, START then fetch at RESET_PC. Also cover pc wrap: 32'hFFFF_FFFC followed by fetch at 0.
